// File: rtl/spi3w_slave_regs_pkg.sv
// rtl/spi3w_slave_regs_pkg.sv - protocol constants, FSM state and W1W0 decode for the 3-wire SPI responder
package spi3w_slave_regs_pkg;

  localparam int HDR_LEN    = 16;
  localparam int RW_BIT     = 15;
  localparam int W1W0_HI    = 14;
  localparam int W1W0_LO    = 13;
  localparam int HDR_ADDR_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    W1W0_ONE    = 2'b00,
    W1W0_TWO    = 2'b01,
    W1W0_THREE  = 2'b10,
    W1W0_STREAM = 2'b11
  } w1w0_t;

  // Byte count for a fixed-length transfer; stream transfers never consult it.
  function automatic logic [1:0] w1w0_bytes(input logic [1:0] w1w0);
    return w1w0 + 2'd1;
  endfunction

endpackage

// File: rtl/spi3w_slave_regs_if.sv
// rtl/spi3w_slave_regs_if.sv - SPI pin and fabric register-port bundle for the 3-wire SPI responder
interface spi3w_slave_regs_if #(
  parameter int ADDR_W = 13
) ();

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              sdio_i;
  logic              sdio_o;
  logic              sdio_oe;
  logic              o_busy;
  logic              o_wr_valid;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [7:0]        o_rd_data;

  modport slave (
    input  spi_sclk, spi_cs_n, sdio_i, i_rd_addr,
    output sdio_o, sdio_oe, o_busy, o_wr_valid, o_wr_addr, o_wr_data, o_rd_data
  );

  modport master (
    output spi_sclk, spi_cs_n, sdio_i, i_rd_addr,
    input  sdio_o, sdio_oe, o_busy, o_wr_valid, o_wr_addr, o_wr_data, o_rd_data
  );

endinterface

// File: rtl/spi3w_slave_regs_in_sync.sv
// rtl/spi3w_slave_regs_in_sync.sv - synchronises sclk/cs_n/sdio into clk and derives sclk edges and cs_n fall
module spi3w_slave_regs_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sclk,
  input  logic cs_n,
  input  logic sdio,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic cs_fall,
  output logic sdio_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sdio_q;
  logic                   sclk_d;
  logic                   cs_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      cs_q   <= '1;
      sdio_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sdio_q <= {sdio_q[SYNC_STAGES-2:0], sdio};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  // sdio goes through the same depth as sclk, so a rise pulse lines up with the bit it clocks.
  assign cs_n_s    = cs_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_d & ~cs_n_s;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_d & ~cs_n_s;
  assign cs_fall   = ~cs_n_s & cs_d;

endmodule

// File: rtl/spi3w_slave_regs.sv
// rtl/spi3w_slave_regs.sv - oversampled 3-wire SPI responder backed by a byte register file
// Optional: SPI3W_SLAVE_SOFT_RST_EN makes a write of bit5/bit2 to address 0 clear the register file.
module spi3w_slave_regs
  import spi3w_slave_regs_pkg::*;
#(
  parameter int ADDR_W      = HDR_ADDR_W,
  parameter int REG_DEPTH   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  spi3w_slave_regs_if.slave   bus
);

  localparam int              IDX_W   = $clog2(REG_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(REG_DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_A;
  endfunction

  logic sclk_rise, sclk_fall, cs_n_s, cs_fall, sdio_s;

  spi3w_slave_regs_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk       (clk),
    .rstn      (rstn),
    .sclk      (bus.spi_sclk),
    .cs_n      (bus.spi_cs_n),
    .sdio      (bus.sdio_i),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .cs_fall   (cs_fall),
    .sdio_s    (sdio_s)
  );

  state_t              state;
  logic [HDR_LEN-2:0]  hdr_sh;
  logic [HDR_LEN-1:0]  hdr_next;
  logic [4:0]          bit_cnt;
  logic [7:0]          tx_sh;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          bytes_left;
  logic                stream;
  logic                rd_last;
  logic                sdio_o_q;
  logic                sdio_oe_q;
  logic                wr_valid;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic [7:0]          rd_data;
  logic [7:0]          rd_byte;
  logic [7:0]          mem [REG_DEPTH];

  assign hdr_next = {hdr_sh, sdio_s};

  always_comb begin
    rd_byte = 8'h00;
    if (in_range(addr)) rd_byte = mem[addr[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      hdr_sh     <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      addr       <= '0;
      bytes_left <= '0;
      stream     <= 1'b0;
      rd_last    <= 1'b0;
      sdio_o_q   <= 1'b0;
      sdio_oe_q  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (cs_n_s && state != IDLE) begin
        // cs_n high aborts anything in flight; partial bytes are simply dropped
        state     <= IDLE;
        sdio_oe_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sdio_oe_q <= 1'b0;
            if (cs_fall) begin
              state   <= HDR;
              bit_cnt <= '0;
            end
          end
          HDR: begin
            if (sclk_rise) begin
              hdr_sh  <= hdr_next[HDR_LEN-2:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'(HDR_LEN - 1)) begin
                addr       <= hdr_next[ADDR_W-1:0];
                stream     <= (hdr_next[W1W0_HI:W1W0_LO] == W1W0_STREAM);
                bytes_left <= w1w0_bytes(hdr_next[W1W0_HI:W1W0_LO]);
                rd_last    <= 1'b0;
                bit_cnt    <= '0;
                state      <= hdr_next[RW_BIT] ? RDATA : WDATA;
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              hdr_sh  <= hdr_next[HDR_LEN-2:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= hdr_next[7:0];
                addr     <= addr - 1'b1;
                bit_cnt  <= '0;
                if (!stream) begin
                  if (bytes_left == 2'd1) state <= DONE;
                  else                    bytes_left <= bytes_left - 2'd1;
                end
              end
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              if (bit_cnt == 5'd0) begin
                // byte boundary: the previous byte's last bit has been sampled by now
                if (rd_last) begin
                  state     <= DONE;
                  sdio_oe_q <= 1'b0;
                end else begin
                  sdio_oe_q <= 1'b1;
                  sdio_o_q  <= rd_byte[7];
                  tx_sh     <= {rd_byte[6:0], 1'b0};
                  bit_cnt   <= 5'd1;
                end
              end else begin
                sdio_o_q <= tx_sh[7];
                tx_sh    <= {tx_sh[6:0], 1'b0};
                if (bit_cnt == 5'd7) begin
                  bit_cnt <= '0;
                  addr    <= addr - 1'b1;
                  if (!stream) begin
                    if (bytes_left == 2'd1) rd_last <= 1'b1;
                    else                    bytes_left <= bytes_left - 2'd1;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 5'd1;
                end
              end
            end
          end
          DONE: begin
            sdio_oe_q <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            sdio_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Storage commits in the cycle wr_valid is high, so a same-cycle fabric read still sees the old byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_valid && in_range(wr_addr)) begin
`ifdef SPI3W_SLAVE_SOFT_RST_EN
      if (wr_addr == '0 && (wr_data[5] || wr_data[2])) begin
        for (int i = 1; i < REG_DEPTH; i++) mem[i] <= 8'h00;
        mem[0] <= wr_data & 8'hDB;
      end else begin
        mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
`else
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= in_range(bus.i_rd_addr) ? mem[bus.i_rd_addr[IDX_W-1:0]] : 8'h00;
    end
  end

  assign bus.sdio_o     = sdio_o_q;
  assign bus.sdio_oe    = sdio_oe_q;
  assign bus.o_busy     = ~cs_n_s;
  assign bus.o_wr_valid = wr_valid;
  assign bus.o_wr_addr  = wr_addr;
  assign bus.o_wr_data  = wr_data;
  assign bus.o_rd_data  = rd_data;

endmodule

// File: tb/tb_spi3w_slave_regs.sv
// tb/tb_spi3w_slave_regs.sv - directed-vector bench for spi3w_slave_regs
module tb_spi3w_slave_regs;

  localparam int HALF = 80;

  logic clk;
  logic rstn;

  spi3w_slave_regs_if #(.ADDR_W(13)) bus ();

  spi3w_slave_regs #(
    .ADDR_W      (13),
    .REG_DEPTH   (256),
    .SYNC_STAGES (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [12:0] wr_a [$];
  logic [7:0]  wr_d [$];
  logic        coll_arm;
  int          coll_ph;
  logic [7:0]  coll_old;
  logic [7:0]  coll_new;
  logic        rd_oe_all;
  logic        busy_seen;

  always @(negedge clk) begin
    if (coll_ph == 1) begin
      coll_old = bus.o_rd_data;
      coll_ph  = 2;
    end else if (coll_ph == 2) begin
      coll_new = bus.o_rd_data;
      coll_ph  = 3;
    end
    if (bus.o_wr_valid) begin
      wr_a.push_back(bus.o_wr_addr);
      wr_d.push_back(bus.o_wr_data);
      if (coll_arm) begin
        coll_ph  = 1;
        coll_arm = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_on();
    @(negedge clk);
    wr_a.delete();
    wr_d.delete();
    bus.spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_off();
    #(HALF);
    busy_seen = bus.o_busy;
    bus.spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    bus.sdio_i = b;
    #(HALF);
    bus.spi_sclk = 1'b1;
    #(HALF);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) shift_bit(b[i]);
  endtask

  task automatic shift_hdr(input logic [15:0] h);
    for (int i = 15; i >= 0; i--) shift_bit(h[i]);
  endtask

  task automatic read_byte(output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #(HALF);
      rd_oe_all = rd_oe_all & bus.sdio_oe;
      b = {b[6:0], bus.sdio_oe ? bus.sdio_o : bus.sdio_i};
      bus.spi_sclk = 1'b1;
      #(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_write1(input logic [15:0] h, input logic [7:0] d);
    cs_on();
    shift_hdr(h);
    shift_byte(d);
    cs_off();
  endtask

  task automatic rd_port(input logic [12:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.i_rd_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = bus.o_rd_data;
  endtask

  logic [7:0] rv;
  logic [7:0] rv2;

  initial begin
    n_vec        = 0;
    n_err        = 0;
    coll_arm     = 1'b0;
    coll_ph      = 0;
    coll_old     = 8'h00;
    coll_new     = 8'h00;
    rd_oe_all    = 1'b1;
    busy_seen    = 1'b0;
    rstn         = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.sdio_i   = 1'b0;
    bus.i_rd_addr = 13'h000;
    repeat (5) @(negedge clk);
    chk("rst_oe",      bus.sdio_oe,    0);
    chk("rst_sdio_o",  bus.sdio_o,     0);
    chk("rst_busy",    bus.o_busy,     0);
    chk("rst_wr_vld",  bus.o_wr_valid, 0);
    chk("rst_wr_addr", bus.o_wr_addr,  0);
    chk("rst_wr_data", bus.o_wr_data,  0);
    chk("rst_rd_data", bus.o_rd_data,  0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // single-byte write
    spi_write1(16'h0010, 8'hA5);
    chk("w1_busy", busy_seen, 1);
    chk("w1_cnt",  wr_a.size(), 1);
    chk("w1_addr", wr_a[0], 13'h010);
    chk("w1_data", wr_d[0], 8'hA5);
    chk("w1_idle_busy", bus.o_busy, 0);
    rd_port(13'h010, rv);
    chk("w1_rd", rv, 8'hA5);

    // three-byte descending write
    cs_on();
    shift_hdr(16'h4012);
    shift_byte(8'h11);
    shift_byte(8'h22);
    shift_byte(8'h33);
    cs_off();
    chk("w3_cnt",   wr_a.size(), 3);
    chk("w3_a0",    wr_a[0], 13'h012);
    chk("w3_d0",    wr_d[0], 8'h11);
    chk("w3_a1",    wr_a[1], 13'h011);
    chk("w3_d1",    wr_d[1], 8'h22);
    chk("w3_a2",    wr_a[2], 13'h010);
    chk("w3_d2",    wr_d[2], 8'h33);
    rd_port(13'h012, rv);
    chk("w3_rd12", rv, 8'h11);
    rd_port(13'h011, rv);
    chk("w3_rd11", rv, 8'h22);
    rd_port(13'h010, rv);
    chk("w3_rd10", rv, 8'h33);

    // single-byte read
    spi_write1(16'h0005, 8'h5A);
    cs_on();
    shift_hdr(16'h8005);
    rd_oe_all = 1'b1;
    read_byte(rv);
    chk("r1_oe_during", rd_oe_all, 1);
    cs_off();
    chk("r1_data",   rv, 8'h5A);
    chk("r1_no_wr",  wr_a.size(), 0);
    chk("r1_oe_end", bus.sdio_oe, 0);

    // two-byte descending read
    cs_on();
    shift_hdr(16'hA012);
    rd_oe_all = 1'b1;
    read_byte(rv);
    read_byte(rv2);
    cs_off();
    chk("r2_oe_during", rd_oe_all, 1);
    chk("r2_b0", rv,  8'h11);
    chk("r2_b1", rv2, 8'h22);

    // abort in the middle of a data byte
    cs_on();
    shift_hdr(16'h0020);
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    cs_off();
    chk("ab_no_wr", wr_a.size(), 0);
    rd_port(13'h020, rv);
    chk("ab_rd", rv, 8'h00);
    spi_write1(16'h0020, 8'h3C);
    chk("ab_next_cnt", wr_a.size(), 1);
    chk("ab_next_d",   wr_d[0], 8'h3C);
    rd_port(13'h020, rv);
    chk("ab_next_rd", rv, 8'h3C);

    // out-of-range address
    spi_write1(16'h0100, 8'h77);
    chk("oor_cnt",  wr_a.size(), 1);
    chk("oor_addr", wr_a[0], 13'h100);
    chk("oor_data", wr_d[0], 8'h77);
    rd_port(13'h100, rv);
    chk("oor_rd", rv, 8'h00);
    rd_port(13'h000, rv);
    chk("oor_rd0", rv, 8'h00);
    cs_on();
    shift_hdr(16'h8100);
    read_byte(rv);
    cs_off();
    chk("oor_spi_rd", rv, 8'h00);

    // commit and fabric read of the same address in the same cycle
    @(negedge clk);
    bus.i_rd_addr = 13'h030;
    coll_ph  = 0;
    coll_arm = 1'b1;
    spi_write1(16'h0030, 8'h99);
    chk("coll_ph",  coll_ph, 3);
    chk("coll_old", coll_old, 8'h00);
    chk("coll_new", coll_new, 8'h99);

    // write of 0x24 to address 0
    spi_write1(16'h0000, 8'h24);
    chk("sr_cnt",  wr_a.size(), 1);
    chk("sr_data", wr_d[0], 8'h24);
`ifdef SPI3W_SLAVE_SOFT_RST_EN
    rd_port(13'h000, rv);
    chk("sr_rd0", rv, 8'h00);
    rd_port(13'h010, rv);
    chk("sr_rd10", rv, 8'h00);
    rd_port(13'h005, rv);
    chk("sr_rd05", rv, 8'h00);
`else
    rd_port(13'h000, rv);
    chk("sr_rd0", rv, 8'h24);
    rd_port(13'h010, rv);
    chk("sr_rd10", rv, 8'h33);
    rd_port(13'h005, rv);
    chk("sr_rd05", rv, 8'h5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
